// File: rtl/simd_alu_pkg.sv
// simd_alu_pkg: shared definitions for the packed-SIMD ALU.
//   - DATA_W         vector width (only 256 is supported)
//   - opcode_e       4-bit instruction opcode
//   - dm_e           3-bit element-width mode
//   - field positions of the 16-bit instruction word
package simd_alu_pkg;

  localparam int DATA_W = 256;
  localparam int INST_W = 16;

  // Instruction word layout: [15:12] opcode, [11:9] DM, [8] IMMF, [7:0] IMM
  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 12;
  localparam int DM_MSB   = 11;
  localparam int DM_LSB   = 9;
  localparam int IMMF_BIT = 8;
  localparam int IMM_MSB  = 7;
  localparam int IMM_LSB  = 0;

  // Codes 10-15 are reserved and produce a zero result.
  typedef enum logic [3:0] {
    NOP    = 4'd0,
    PADD   = 4'd1,
    PSUB   = 4'd2,
    PSLL   = 4'd3,
    PSRL   = 4'd4,
    PSRA   = 4'd5,
    PCMPEQ = 4'd6,
    PCMPGT = 4'd7,
    UNPKLO = 4'd8,
    UNPKHI = 4'd9
  } opcode_e;

  // Codes 1xx are invalid and produce a zero result.
  typedef enum logic [2:0] {
    E8  = 3'd0,
    E16 = 3'd1,
    E32 = 3'd2,
    E64 = 3'd3
  } dm_e;

endpackage

// File: rtl/simd_alu_if.sv
// simd_alu_if: execution-stage bus of the SIMD ALU.
//   inst  16-bit instruction word (upstream -> ALU)
//   in_A  operand A, element 0 at LSBs (upstream -> ALU)
//   in_B  operand B, same packing      (upstream -> ALU)
//   out   registered result            (ALU -> writeback)
// master: the issuing side; slave: the ALU.
interface simd_alu_if;

  logic [simd_alu_pkg::INST_W-1:0] inst;
  logic [simd_alu_pkg::DATA_W-1:0] in_A;
  logic [simd_alu_pkg::DATA_W-1:0] in_B;
  logic [simd_alu_pkg::DATA_W-1:0] out;

  modport master (output inst, output in_A, output in_B, input  out);
  modport slave  (input  inst, input  in_A, input  in_B, output out);

endinterface

// File: rtl/simd_alu_lane.sv
// simd_alu_lane: one element of width W for the element-wise operations
// (add, sub, logical/arithmetic shifts, equal / signed-greater compares).
//   i_a, i_b  element operands
//   i_op      decoded opcode; anything not element-wise yields 0
//   o_y       element result (combinational)
module simd_alu_lane
  import simd_alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  opcode_e      i_op,
  output logic [W-1:0] o_y
);

  localparam int SW = $clog2(W);

  // Shift amount is only the low log2(W) bits; higher B bits never matter.
  logic [SW-1:0] w_sh;
  assign w_sh = i_b[SW-1:0];

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves
    // o_y unassigned, which would infer a latch.
    o_y = '0;
    case (i_op)
      PADD:    o_y = i_a + i_b;
      PSUB:    o_y = i_a - i_b;
      PSLL:    o_y = i_a << w_sh;
      PSRL:    o_y = i_a >> w_sh;
      PSRA:    o_y = $signed(i_a) >>> w_sh;
      PCMPEQ:  o_y = {W{i_a == i_b}};
      PCMPGT:  o_y = {W{$signed(i_a) > $signed(i_b)}};
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/simd_alu.sv
// simd_alu: 256-bit packed-SIMD integer ALU, one result per clock.
//   clk  rising-edge clock
//   rst  asynchronous active-low reset, clears the result
//   bus  simd_alu_if.slave: inst / in_A / in_B in, registered out
// Every element width is computed in parallel; DM then picks one.
module simd_alu
  import simd_alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  simd_alu_if.slave   bus
);

  opcode_e    w_op;
  dm_e        w_dm;
  logic       w_immf;
  logic [7:0] w_imm;
  logic       w_use_imm;

  assign w_op   = opcode_e'(bus.inst[OP_MSB:OP_LSB]);
  assign w_dm   = dm_e'(bus.inst[DM_MSB:DM_LSB]);
  assign w_immf = bus.inst[IMMF_BIT];
  assign w_imm  = bus.inst[IMM_MSB:IMM_LSB];

  // Compares and unpacks always read in_B regardless of IMMF.
  assign w_use_imm = w_immf && (w_op inside {PADD, PSUB, PSLL, PSRL, PSRA});

  // Index k: element width 8 << k.
  logic [3:0][DATA_W-1:0] w_lane_res;
  logic [3:0][DATA_W-1:0] w_unlo;
  logic [3:0][DATA_W-1:0] w_unhi;

  for (genvar k = 0; k < 4; k++) begin : g_width
    localparam int W = 8 << k;
    localparam int N = DATA_W / W;

    logic [W-1:0]      w_imm_ext;
    logic [DATA_W-1:0] w_b;

    assign w_imm_ext = W'($signed(w_imm));
    assign w_b       = w_use_imm ? {N{w_imm_ext}} : bus.in_B;

    for (genvar i = 0; i < N; i++) begin : g_lane
      simd_alu_lane #(.W(W)) u_lane (
        .i_a  (bus.in_A[i*W +: W]),
        .i_b  (w_b[i*W +: W]),
        .i_op (w_op),
        .o_y  (w_lane_res[k][i*W +: W])
      );
    end

    // Interleave: even result elements from B, odd from A.
    for (genvar i = 0; i < N/2; i++) begin : g_unpk
      assign w_unlo[k][(2*i)*W   +: W] = bus.in_B[i*W +: W];
      assign w_unlo[k][(2*i+1)*W +: W] = bus.in_A[i*W +: W];
      assign w_unhi[k][(2*i)*W   +: W] = bus.in_B[(N/2+i)*W +: W];
      assign w_unhi[k][(2*i+1)*W +: W] = bus.in_A[(N/2+i)*W +: W];
    end
  end

  logic [1:0] w_wsel;
  logic       w_dm_ok;

  always_comb begin
    w_wsel  = 2'd0;
    w_dm_ok = 1'b1;
    case (w_dm)
      E8:      w_wsel = 2'd0;
      E16:     w_wsel = 2'd1;
      E32:     w_wsel = 2'd2;
      E64:     w_wsel = 2'd3;
      default: w_dm_ok = 1'b0;
    endcase
  end

  logic [DATA_W-1:0] w_next;

  always_comb begin
    w_next = '0;
    if (w_dm_ok) begin
      case (w_op)
        PADD, PSUB, PSLL, PSRL, PSRA, PCMPEQ, PCMPGT:
                 w_next = w_lane_res[w_wsel];
        UNPKLO:  w_next = w_unlo[w_wsel];
        UNPKHI:  w_next = w_unhi[w_wsel];
        default: w_next = '0;
      endcase
    end
  end

  logic [DATA_W-1:0] r_out;

  // NOTE: non-blocking assignment for registered state so every flop
  // samples its inputs from before the clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_out <= '0;
    else      r_out <= w_next;
  end

  assign bus.out = r_out;

endmodule

// File: tb/tb_simd_alu.sv
// tb_simd_alu: self-checking bench for simd_alu. Instructions are issued
// back-to-back on the falling edge; the expected result is queued at issue
// and compared on the following falling edge, one clock after capture.
module tb_simd_alu;
  import simd_alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  simd_alu_if bus ();

  simd_alu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string        tag;
    logic [255:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] dm,
                                     input logic immf, input logic [7:0] imm);
    return {op, dm, immf, imm};
  endfunction

  function automatic logic [255:0] rep8(input logic [7:0] x);
    return {32{x}};
  endfunction

  function automatic logic [255:0] rep64(input logic [63:0] x);
    return {4{x}};
  endfunction

  task automatic compare_pending();
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, bus.out, e.exp);
    end
  endtask

  // Falling edge: check the previous instruction, then drive the next one.
  task automatic issue(input string tag, input logic [15:0] inst,
                       input logic [255:0] a, input logic [255:0] b,
                       input logic [255:0] exp);
    exp_t e;
    @(negedge clk);
    compare_pending();
    bus.inst = inst;
    bus.in_A = a;
    bus.in_B = b;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    @(negedge clk);
    compare_pending();
  endtask

  localparam logic [255:0] ONES = '1;
  localparam logic [255:0] PAT_AA = {32{8'hAA}};
  localparam logic [255:0] HALF_80_93 = {{16{8'h80}}, {16{8'h93}}};
  localparam logic [255:0] HALF_D3_57 = {{16{8'hD3}}, {16{8'h57}}};
  localparam logic [255:0] HALF_D3_5F = {{16{8'hD3}}, {16{8'h5F}}};
  localparam logic [255:0] LO_ONES = {{128{1'b0}}, {128{1'b1}}};
  localparam logic [255:0] HI_ONES = {{128{1'b1}}, {128{1'b0}}};

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.inst = '0;
    bus.in_A = '0;
    bus.in_B = '0;

    #1 rst = 1'b0;
    #1 check("reset_state", bus.out, '0);
    @(negedge clk);
    rst = 1'b1;

    // Add / subtract, all widths, register and immediate forms
    issue("padd8",   mk(PADD, E8,  1'b0, 8'hCC), ONES, PAT_AA, rep8(8'hA9));
    issue("paddi8",  mk(PADD, E8,  1'b1, 8'hCC), ONES, PAT_AA, rep8(8'hCB));
    issue("paddi64", mk(PADD, E64, 1'b1, 8'hCC), ONES, PAT_AA, rep64(64'hFFFF_FFFF_FFFF_FFCB));
    issue("padd16",  mk(PADD, E16, 1'b0, 8'hCC), ONES, PAT_AA, {16{16'hAAA9}});
    issue("padd32",  mk(PADD, E32, 1'b0, 8'hCC), ONES, PAT_AA, {8{32'hAAAA_AAA9}});
    issue("psub8",   mk(PSUB, E8,  1'b0, 8'hCC), ONES, PAT_AA, rep8(8'h55));
    issue("psubi8",  mk(PSUB, E8,  1'b1, 8'hCC), ONES, PAT_AA, rep8(8'h33));
    issue("psub64",  mk(PSUB, E64, 1'b0, 8'hCC), ONES, PAT_AA, rep8(8'h55));
    issue("psubi64", mk(PSUB, E64, 1'b1, 8'hCC), ONES, PAT_AA, rep64(64'h33));

    // Shifts
    issue("psll8",   mk(PSLL, E8,  1'b0, 8'hCC), ONES, PAT_AA, rep8(8'hFC));
    issue("pslli8",  mk(PSLL, E8,  1'b1, 8'hCC), ONES, PAT_AA, rep8(8'hF0));
    issue("psll64",  mk(PSLL, E64, 1'b0, 8'hCC), ONES, PAT_AA, rep64({{22{1'b1}}, {42{1'b0}}}));
    issue("pslli64", mk(PSLL, E64, 1'b1, 8'hCC), ONES, PAT_AA, rep64({{52{1'b1}}, {12{1'b0}}}));
    issue("psrl8",   mk(PSRL, E8,  1'b0, 8'hCC), ONES, PAT_AA, rep8(8'h3F));
    issue("psrli8",  mk(PSRL, E8,  1'b1, 8'hCC), ONES, PAT_AA, rep8(8'h0F));
    issue("psrl64",  mk(PSRL, E64, 1'b0, 8'hCC), ONES, PAT_AA, rep64({{42{1'b0}}, {22{1'b1}}}));
    issue("psrli64", mk(PSRL, E64, 1'b1, 8'hCC), ONES, PAT_AA, rep64({{12{1'b0}}, {52{1'b1}}}));
    issue("psrl16",  mk(PSRL, E16, 1'b0, 8'hCC), ONES, PAT_AA, {16{16'h003F}});
    issue("pslli8_zero", mk(PSLL, E8, 1'b1, 8'h00), PAT_AA, ONES, PAT_AA);
    issue("psra8",   mk(PSRA, E8,  1'b0, 8'hCC), rep8(8'h80), PAT_AA, rep8(8'hE0));
    issue("psrai8",  mk(PSRA, E8,  1'b1, 8'hCC), rep8(8'h80), PAT_AA, rep8(8'hF8));
    issue("psrai64", mk(PSRA, E64, 1'b1, 8'hCC), rep8(8'h80), PAT_AA, rep64(64'hFFF8_0808_0808_0808));

    // Compares; the IMMF form checks that the immediate is ignored
    issue("pcmpeq8",  mk(PCMPEQ, E8,  1'b0, 8'h00), rep8(8'h93), HALF_80_93, LO_ONES);
    issue("pcmpeq64", mk(PCMPEQ, E64, 1'b0, 8'h00), rep8(8'h93), HALF_80_93, LO_ONES);
    issue("pcmpeq8_immf", mk(PCMPEQ, E8, 1'b1, 8'h93), rep8(8'h93), HALF_80_93, LO_ONES);
    issue("pcmpgt8",  mk(PCMPGT, E8,  1'b0, 8'h00), rep8(8'h53), HALF_D3_57, HI_ONES);

    // Unpack interleave
    issue("unpklo8",  mk(UNPKLO, E8,  1'b0, 8'h00), rep8(8'h53), HALF_D3_5F, {16{16'h535F}});
    issue("unpkhi8",  mk(UNPKHI, E8,  1'b0, 8'h00), rep8(8'h53), HALF_D3_5F, {16{16'h53D3}});
    issue("unpklo64", mk(UNPKLO, E64, 1'b0, 8'h00), rep8(8'h53), HALF_D3_5F,
          {2{{8{8'h53}}, {8{8'h5F}}}});

    // Zero-result controls
    issue("nop",      mk(NOP,   E8,   1'b0, 8'hCC), ONES, PAT_AA, '0);
    issue("reserved", mk(4'hF,  E8,   1'b0, 8'hCC), ONES, PAT_AA, '0);
    issue("dm_1xx",   mk(PADD,  3'd4, 1'b0, 8'hCC), ONES, PAT_AA, '0);
    issue("padd8_again", mk(PADD, E8, 1'b0, 8'hCC), ONES, PAT_AA, rep8(8'hA9));
    drain();

    // Asynchronous reset mid-stream: out holds A9 bytes here
    #2 rst = 1'b0;
    #1 check("rst_async", bus.out, '0);
    @(posedge clk);
    #1 check("rst_hold", bus.out, '0);
    @(negedge clk);
    rst = 1'b1;

    issue("post_rst_psub8", mk(PSUB, E8, 1'b0, 8'hCC), ONES, PAT_AA, rep8(8'h55));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
